// File: rtl/floatdiv_pkg.sv
// Shared constants and enums for the sequential binary32 divider.
package floatdiv_pkg;
    localparam int          EXP_BIAS  = 127;
    localparam int          EXP_MAX   = 255;
    localparam logic [31:0] QNAN      = 32'h7FC0_0000;
    localparam int          DIV_STEPS = 25;

    typedef enum logic [1:0] {IDLE, DIV, PACK, DONE} state_t;
    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fclass_t;
endpackage

// File: rtl/fp_classify.sv
// Binary32 operand classifier; subnormals report as ZERO (flush-to-zero).
module fp_classify
    import floatdiv_pkg::*;
(
    input  logic [31:0] x,
    output logic [1:0]  cls
);
    always_comb begin
        cls = NORM;
        if (x[30:23] == 8'h00)
            cls = ZERO;
        else if (x[30:23] == 8'hFF)
            cls = (x[22:0] == 23'd0) ? INF : NAN;
    end
endmodule

// File: rtl/floatdiv_seq.sv
// Sequential binary32 divider: restoring mantissa division, one quotient bit
// per cycle, truncating, flush-to-zero, start/done handshake.
module floatdiv_seq
    import floatdiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] rez
);
    logic [1:0]  cls_a, cls_b;
    state_t      state;
    fclass_t     ca, cb;
    logic [4:0]  cnt;
    logic [24:0] rem, quo;
    logic [23:0] mb;
    logic [7:0]  ea, eb;
    logic        sgn;

    fp_classify u_cls_a (.x(a), .cls(cls_a));
    fp_classify u_cls_b (.x(b), .cls(cls_b));

    logic        ge;
    logic [24:0] rem_sub, rem_nxt;
    assign ge      = rem >= {1'b0, mb};
    assign rem_sub = ge ? rem - {1'b0, mb} : rem;
    assign rem_nxt = {rem_sub[23:0], 1'b0};

    // Exponent in 10-bit two's complement so under/overflow stay visible.
    logic signed [9:0] e_q;
    logic [22:0]       mant;
    logic [31:0]       spec_rez, norm_rez;

    always_comb begin
        e_q  = {2'b00, ea} - {2'b00, eb} + (quo[24] ? 10'(EXP_BIAS) : 10'(EXP_BIAS - 1));
        mant = quo[24] ? quo[23:1] : quo[22:0];
        if (e_q >= $signed(10'(EXP_MAX)))
            norm_rez = {sgn, 8'hFF, 23'd0};
        else if (e_q <= 10'sd0)
            norm_rez = {sgn, 31'd0};
        else
            norm_rez = {sgn, e_q[7:0], mant};
    end

    always_comb begin
        if (ca == NAN || cb == NAN || (ca == ZERO && cb == ZERO) || (ca == INF && cb == INF))
            spec_rez = QNAN;
        else if (ca == INF || cb == ZERO)
            spec_rez = {sgn, 8'hFF, 23'd0};
        else
            spec_rez = {sgn, 31'd0};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            rez   <= 32'd0;
            cnt   <= 5'd0;
            rem   <= 25'd0;
            quo   <= 25'd0;
            mb    <= 24'd0;
            ea    <= 8'd0;
            eb    <= 8'd0;
            sgn   <= 1'b0;
            ca    <= ZERO;
            cb    <= ZERO;
        end else begin
            case (state)
                IDLE: if (start) begin
                    busy  <= 1'b1;
                    sgn   <= a[31] ^ b[31];
                    ea    <= a[30:23];
                    eb    <= b[30:23];
                    mb    <= {1'b1, b[22:0]};
                    rem   <= {2'b01, a[22:0]};
                    quo   <= 25'd0;
                    cnt   <= 5'd0;
                    ca    <= fclass_t'(cls_a);
                    cb    <= fclass_t'(cls_b);
                    state <= (cls_a == NORM && cls_b == NORM) ? DIV : PACK;
                end
                DIV: begin
                    quo <= {quo[23:0], ge};
                    rem <= rem_nxt;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(DIV_STEPS - 1))
                        state <= PACK;
                end
                PACK: begin
                    rez   <= (ca == NORM && cb == NORM) ? norm_rez : spec_rez;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_floatdiv_seq.sv
// Scoreboard bench for floatdiv_seq: spec vectors plus a reference model.
module tb_floatdiv_seq;
    logic        clk = 1'b0;
    logic        reset, start, busy, done;
    logic [31:0] a, b, rez;
    logic [31:0] exp_q[$];
    int          total = 0;
    int          bad = 0;

    floatdiv_seq dut (.clk(clk), .reset(reset), .start(start), .a(a), .b(b),
                      .busy(busy), .done(done), .rez(rez));

    always #5 clk = ~clk;

    // Reference via integer long division of the scaled mantissas.
    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
        logic        s;
        bit          xz, xi, xn, yz, yi, yn;
        longint      q;
        int          e;
        logic [22:0] m;
        s  = x[31] ^ y[31];
        xz = x[30:23] == 8'd0;  xi = x[30:23] == 8'hFF && x[22:0] == 0;  xn = x[30:23] == 8'hFF && x[22:0] != 0;
        yz = y[30:23] == 8'd0;  yi = y[30:23] == 8'hFF && y[22:0] == 0;  yn = y[30:23] == 8'hFF && y[22:0] != 0;
        if (xn || yn || (xz && yz) || (xi && yi)) return 32'h7FC00000;
        if (xi || yz) return {s, 8'hFF, 23'd0};
        if (xz || yi) return {s, 31'd0};
        q = ((longint'(x[22:0]) + 64'h800000) << 24) / (longint'(y[22:0]) + 64'h800000);
        e = int'(x[30:23]) - int'(y[30:23]) + 126;
        if (q >= 64'h1000000) begin m = q[23:1]; e = e + 1; end
        else m = q[22:0];
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], m};
    endfunction

    // Drive one op from IDLE, wait (bounded) for done; lat = edges after accept, -1 on timeout.
    task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input logic [31:0] expv,
                          output int lat, output logic [31:0] res, output logic tail);
        @(negedge clk); a = xa; b = xb; start = 1'b1; exp_q.push_back(expv);
        @(posedge clk); #1; start = 1'b0; a = $urandom; b = $urandom;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
        res = rez;
        @(posedge clk); #1;
        tail = done;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        #12;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (rez !== 32'd0) begin bad++; $display("FAIL reset_rez got=%h want=0", rez); end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_normal();
        logic [31:0] va[3] = '{32'h40C00000, 32'h3F800000, 32'hC0C00000};
        logic [31:0] vb[3] = '{32'h40000000, 32'h40400000, 32'h40000000};
        logic [31:0] ve[3] = '{32'h40400000, 32'h3EAAAAAA, 32'hC0400000};
        logic [31:0] res, got, xa, xb;
        int lat; logic tail;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], ve[i], lat, res, tail);
            got = exp_q.pop_front();
            total++; if (res !== got) begin bad++; $display("FAIL normal_rez[%0d] got=%h want=%h", i, res, got); end
            // done visible in the cycle following edge 26 after accept
            total++; if (lat !== 26) begin bad++; $display("FAIL normal_latency[%0d] got=%0d want=26", i, lat); end
            total++; if (tail !== 1'b0) begin bad++; $display("FAIL normal_done_width[%0d] got=%b want=0", i, tail); end
        end
        for (int i = 0; i < 6; i++) begin
            xa = {1'($urandom), 8'($urandom_range(190, 64)), 23'($urandom)};
            xb = {1'($urandom), 8'($urandom_range(190, 64)), 23'($urandom)};
            run_op(xa, xb, model(xa, xb), lat, res, tail);
            got = exp_q.pop_front();
            total++; if (res !== got) begin bad++; $display("FAIL rand_rez %h/%h got=%h want=%h", xa, xb, res, got); end
            total++; if (lat !== 26) begin bad++; $display("FAIL rand_latency got=%0d want=26", lat); end
        end
    endtask

    task automatic test_specials();
        logic [31:0] va[5] = '{32'h3F800000, 32'h00000000, 32'hBF800000, 32'h7FC12345, 32'hFF800000};
        logic [31:0] vb[5] = '{32'h00000000, 32'h00000000, 32'h7F800000, 32'h3F800000, 32'h7F800000};
        logic [31:0] ve[5] = '{32'h7F800000, 32'h7FC00000, 32'h80000000, 32'h7FC00000, 32'h7FC00000};
        logic [31:0] res, got;
        int lat; logic tail;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], ve[i], lat, res, tail);
            got = exp_q.pop_front();
            total++; if (res !== got) begin bad++; $display("FAIL special_rez[%0d] got=%h want=%h", i, res, got); end
            total++; if (lat !== 1) begin bad++; $display("FAIL special_latency[%0d] got=%0d want=1", i, lat); end
            total++; if (tail !== 1'b0) begin bad++; $display("FAIL special_done_width[%0d] got=%b want=0", i, tail); end
        end
    endtask

    task automatic test_range();
        logic [31:0] res, got;
        int lat; logic tail;
        run_op(32'h7F000000, 32'h3E800000, 32'h7F800000, lat, res, tail);
        got = exp_q.pop_front();
        total++; if (res !== got) begin bad++; $display("FAIL overflow got=%h want=%h", res, got); end
        run_op(32'h00800000, 32'h7F000000, 32'h00000000, lat, res, tail);
        got = exp_q.pop_front();
        total++; if (res !== got) begin bad++; $display("FAIL underflow got=%h want=%h", res, got); end
        run_op(32'h00400000, 32'h3F800000, 32'h00000000, lat, res, tail);
        got = exp_q.pop_front();
        total++; if (res !== got) begin bad++; $display("FAIL subnormal_flush got=%h want=%h", res, got); end
    endtask

    task automatic test_ignore_busy();
        logic [31:0] prev, got;
        int lat, extra;
        prev = rez;
        @(negedge clk); a = 32'h40C00000; b = 32'h40000000; start = 1'b1; exp_q.push_back(32'h40400000);
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
        @(negedge clk); start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_mid got=%b want=1", busy); end
        total++; if (rez !== prev) begin bad++; $display("FAIL rez_hold got=%h want=%h", rez, prev); end
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin lat = i; break; end
        end
        got = exp_q.pop_front();
        total++; if (lat < 0 || rez !== got) begin bad++; $display("FAIL ignore_rez got=%h want=%h lat=%0d", rez, got, lat); end
        extra = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL ignored_start_done got=%0d want=0", extra); end
    endtask

    task automatic test_back_to_back();
        int idx[2]; logic [31:0] r[2]; logic [31:0] got;
        int n = 0;
        idx[0] = -1; idx[1] = -1;
        @(negedge clk); a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        exp_q.push_back(32'h40400000); exp_q.push_back(32'h3EAAAAAA);
        @(posedge clk); #1; a = 32'h3F800000; b = 32'h40400000;
        for (int i = 1; i <= 80 && n < 2; i++) begin
            @(posedge clk); #1;
            if (done) begin idx[n] = i; r[n] = rez; n++; end
        end
        start = 1'b0;
        @(posedge clk); #1;
        total++; if (n !== 2 || idx[1] - idx[0] !== 28) begin bad++; $display("FAIL b2b_spacing got=%0d want=28 (n=%0d)", idx[1] - idx[0], n); end
        for (int k = 0; k < 2; k++) begin
            got = exp_q.pop_front();
            total++; if (r[k] !== got) begin bad++; $display("FAIL b2b_rez[%0d] got=%h want=%h", k, r[k], got); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res, got;
        int lat; logic tail;
        @(negedge clk); a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #1; reset = 1'b1; #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done); end
        total++; if (rez !== 32'd0) begin bad++; $display("FAIL abort_rez got=%h want=0", rez); end
        @(negedge clk); reset = 1'b0;
        run_op(32'hC0C00000, 32'h40000000, 32'hC0400000, lat, res, tail);
        got = exp_q.pop_front();
        total++; if (res !== got) begin bad++; $display("FAIL after_reset_rez got=%h want=%h", res, got); end
        total++; if (lat !== 26) begin bad++; $display("FAIL after_reset_latency got=%0d want=26", lat); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_specials();
        test_range();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
